// File: rtl/video_pattern_timing_gen.sv
// Raster timing and test-pattern source: sync/de/x/y/frame_start plus four selectable patterns.
// Define VPTG_CROSSHAIR_EN to add cursor_x/cursor_y ports and a green crosshair overlay.
module video_pattern_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   HW       = 12,
  parameter int   VW       = 11,
  parameter int   CHK_LOG2 = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
`ifdef VPTG_CROSSHAIR_EN
  input  logic [HW-1:0] cursor_x,
  input  logic [VW-1:0] cursor_y,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_ZERO    = HW'(0);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] LPOS_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ZERO    = VW'(0);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [HW-1:0] B1 = HW'(1 * BAR_W);
  localparam logic [HW-1:0] B2 = HW'(2 * BAR_W);
  localparam logic [HW-1:0] B3 = HW'(3 * BAR_W);
  localparam logic [HW-1:0] B4 = HW'(4 * BAR_W);
  localparam logic [HW-1:0] B5 = HW'(5 * BAR_W);
  localparam logic [HW-1:0] B6 = HW'(6 * BAR_W);
  localparam logic [HW-1:0] B7 = HW'(7 * BAR_W);

  // Bar index by threshold compare; anything at or past 7*BAR_W (incl. remainder) is bar 7.
  function automatic logic [23:0] bar_rgb(input logic [HW-1:0] h);
    logic [23:0] c;
    if (h < B1)      c = 24'hFFFFFF;
    else if (h < B2) c = 24'hFFFF00;
    else if (h < B3) c = 24'h00FFFF;
    else if (h < B4) c = 24'h00FF00;
    else if (h < B5) c = 24'hFF00FF;
    else if (h < B6) c = 24'hFF0000;
    else if (h < B7) c = 24'h0000FF;
    else             c = 24'h000000;
    return c;
  endfunction

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [HW-1:0] lpos;
  logic [1:0]    mode_q;
  logic          h_last;
  logic          v_last;
  logic          origin;
  logic          de_n;
  logic          hs_n;
  logic          vs_n;
  logic [1:0]    mode_eff;
  logic [23:0]   pat;
  logic [23:0]   rgb_n;
`ifdef VPTG_CROSSHAIR_EN
  logic [HW-1:0] cur_x_q;
  logic [VW-1:0] cur_y_q;
  logic [HW-1:0] cur_x_eff;
  logic [VW-1:0] cur_y_eff;
`endif

  // Decode the current counter position into next-cycle output values.
  always_comb begin
    h_last = (hcnt == H_LAST);
    v_last = (vcnt == V_LAST);
    origin = (hcnt == H_ZERO) && (vcnt == V_ZERO);
    de_n   = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_n   = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_n   = (vcnt >= VS_BEG) && (vcnt < VS_END);
    // At the origin the freshly sampled mode applies, so pixel (0,0) already shows the new frame's pattern.
    mode_eff = origin ? mode : mode_q;
    pat      = 24'h000000;
    case (mode_eff)
      2'd0:    pat = solid_rgb;
      2'd1:    pat = bar_rgb(hcnt);
      2'd2:    pat = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      2'd3:    pat = (hcnt == lpos) ? 24'hFFFFFF : 24'hFF0000;
      default: pat = 24'h000000;
    endcase
`ifdef VPTG_CROSSHAIR_EN
    cur_x_eff = origin ? cursor_x : cur_x_q;
    cur_y_eff = origin ? cursor_y : cur_y_q;
    if ((hcnt == cur_x_eff) || (vcnt == cur_y_eff)) begin
      rgb_n = 24'h00FF00;
    end else begin
      rgb_n = pat;
    end
`else
    rgb_n = pat;
`endif
  end

  // Raster counters; disabling forces them back to the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= H_ZERO;
      vcnt <= V_ZERO;
    end else if (!en) begin
      hcnt <= H_ZERO;
      vcnt <= V_ZERO;
    end else if (h_last) begin
      hcnt <= H_ZERO;
      vcnt <= v_last ? V_ZERO : vcnt + V_ONE;
    end else begin
      hcnt <= hcnt + H_ONE;
      vcnt <= vcnt;
    end
  end

  // Moving-line position advances once per completed frame; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lpos <= H_ZERO;
    end else if (en && h_last && v_last) begin
      lpos <= (lpos == LPOS_LAST) ? H_ZERO : lpos + H_ONE;
    end else begin
      lpos <= lpos;
    end
  end

  // Frame-start sampling of the pattern controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'd0;
`ifdef VPTG_CROSSHAIR_EN
      cur_x_q <= H_ZERO;
      cur_y_q <= V_ZERO;
`endif
    end else if (en && origin) begin
      mode_q  <= mode;
`ifdef VPTG_CROSSHAIR_EN
      cur_x_q <= cursor_x;
      cur_y_q <= cursor_y;
`endif
    end else begin
      mode_q  <= mode_q;
`ifdef VPTG_CROSSHAIR_EN
      cur_x_q <= cur_x_q;
      cur_y_q <= cur_y_q;
`endif
    end
  end

  // Output register stage: one cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      x           <= H_ZERO;
      y           <= V_ZERO;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      x           <= H_ZERO;
      y           <= V_ZERO;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_n ? HS_POL : ~HS_POL;
      vsync       <= vs_n ? VS_POL : ~VS_POL;
      de          <= de_n;
      red         <= de_n ? rgb_n[23:16] : 8'h00;
      green       <= de_n ? rgb_n[15:8]  : 8'h00;
      blue        <= de_n ? rgb_n[7:0]   : 8'h00;
      x           <= de_n ? hcnt : H_ZERO;
      y           <= de_n ? vcnt : V_ZERO;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_video_pattern_timing_gen.sv
// Directed bench for video_pattern_timing_gen on a 24x12 raster (16x8 active, 2px checker squares).
`timescale 1ns/1ps
module tb_video_pattern_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [11:0] cursor_x;
  logic [10:0] cursor_y;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [11:0] x;
  logic [10:0] y;
  logic [23:0] rgb;

  int checks   = 0;
  int failures = 0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  video_pattern_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .HW(12), .VW(11), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
`ifdef VPTG_CROSSHAIR_EN
    .cursor_x(cursor_x), .cursor_y(cursor_y),
`endif
    .hsync(hsync), .vsync(vsync), .de(de), .red(red), .green(green), .blue(blue),
    .x(x), .y(y), .frame_start(frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_hs"}, 32'(hsync), 32'd1);
    check_eq({tag, "_vs"}, 32'(vsync), 32'd1);
    check_eq({tag, "_de"}, 32'(de), 32'd0);
    check_eq({tag, "_rgb"}, 32'(rgb), 32'h000000);
    check_eq({tag, "_x"}, 32'(x), 32'd0);
    check_eq({tag, "_y"}, 32'(y), 32'd0);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, white_cnt, lp;
    rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 24'h123456;
    cursor_x = 12'd0; cursor_y = 11'd0;
    #12;
    check_idle("reset");
    tick;
    rst = 1'b0;
    tick;
    check_idle("en_low");
    en = 1'b1;

    // Frames 0..19: timing, mode hold, checker, bars, moving line.
    for (int f = 0; f < 20; f++) begin
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; white_cnt = 0;
      lp = f % 16;
      for (int p = 0; p < 288; p++) begin
        tick;
        if (de) de_cnt++;
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
        if (frame_start) fs_cnt++;
        if (de && rgb == 24'hFFFFFF) white_cnt++;
        if (f == 0) begin
          if (p == 0)   check_eq("t_rgb00", 32'(rgb), 32'h123456);
          if (p == 16)  check_eq("t_de16", 32'(de), 32'd0);
          if (p == 16)  check_eq("t_rgb16", 32'(rgb), 32'h000000);
          if (p == 77)  check_eq("t_x77", 32'(x), 32'd5);
          if (p == 77)  check_eq("t_y77", 32'(y), 32'd3);
          if (p == 17)  check_eq("t_hs17", 32'(hsync), 32'd1);
          if (p == 18)  check_eq("t_hs18", 32'(hsync), 32'd0);
          if (p == 20)  check_eq("t_hs20", 32'(hsync), 32'd0);
          if (p == 21)  check_eq("t_hs21", 32'(hsync), 32'd1);
          if (p == 215) check_eq("t_vs215", 32'(vsync), 32'd1);
          if (p == 216) check_eq("t_vs216", 32'(vsync), 32'd0);
          if (p == 263) check_eq("t_vs263", 32'(vsync), 32'd0);
          if (p == 264) check_eq("t_vs264", 32'(vsync), 32'd1);
          if (p == 100) mode = 2'd2;
          if (p == 120) check_eq("hold_rgb", 32'(rgb), 32'h123456);
        end
        if (f == 1) begin
          if (p == 0)   check_eq("chk_0_0", 32'(rgb), 32'h000000);
          if (p == 2)   check_eq("chk_2_0", 32'(rgb), 32'hFFFFFF);
          if (p == 48)  check_eq("chk_0_2", 32'(rgb), 32'hFFFFFF);
          if (p == 50)  check_eq("chk_2_2", 32'(rgb), 32'h000000);
          if (p == 100) mode = 2'd1;
        end
        if (f == 2) begin
          if (p == 0)   check_eq("bar_x0", 32'(rgb), 32'hFFFFFF);
          if (p == 1)   check_eq("bar_x1", 32'(rgb), 32'hFFFFFF);
          if (p == 4)   check_eq("bar_x4", 32'(rgb), 32'h00FFFF);
          if (p == 10)  check_eq("bar_x10", 32'(rgb), 32'hFF0000);
          if (p == 11)  check_eq("bar_x11", 32'(rgb), 32'hFF0000);
          if (p == 14)  check_eq("bar_x14", 32'(rgb), 32'h000000);
          if (p == 15)  check_eq("bar_x15", 32'(rgb), 32'h000000);
          if (p == 17)  check_eq("bar_x17", 32'(rgb), 32'h000000);
          if (p == 23)  check_eq("bar_x23", 32'(rgb), 32'h000000);
          if (p == 100) mode = 2'd3;
        end
        if (f >= 3) begin
          if (p == 0) begin
            check_eq("ml_fs", 32'(frame_start), 32'd1);
            check_eq("ml_de0", 32'(de), 32'd1);
            check_eq("ml_x0", 32'(x), 32'd0);
            check_eq("ml_y0", 32'(y), 32'd0);
          end
          if (p == lp)            check_eq("ml_white", 32'(rgb), 32'hFFFFFF);
          if (p == (lp + 1) % 16) check_eq("ml_red", 32'(rgb), 32'hFF0000);
        end
      end
      check_eq("cnt_de", 32'(de_cnt), 32'd128);
      check_eq("cnt_hs", 32'(hs_cnt), 32'd36);
      check_eq("cnt_vs", 32'(vs_cnt), 32'd48);
      check_eq("cnt_fs", 32'(fs_cnt), 32'd1);
      if (f >= 3) check_eq("cnt_white", 32'(white_cnt), 32'd8);
    end

    // Drop enable mid-frame, then restart at the origin (lpos is now 4).
    for (int p = 0; p < 80; p++) tick;
    check_eq("pre_x", 32'(x), 32'd7);
    check_eq("pre_y", 32'(y), 32'd3);
    en = 1'b0;
    tick;
    check_idle("en_drop");
    en = 1'b1;
    tick;
    check_eq("re_fs", 32'(frame_start), 32'd1);
    check_eq("re_de", 32'(de), 32'd1);
    check_eq("re_rgb0", 32'(rgb), 32'hFF0000);
    for (int p = 1; p <= 4; p++) tick;
    check_eq("re_rgb4", 32'(rgb), 32'hFFFFFF);

    // Asynchronous reset mid-line, then release with en held high.
    for (int p = 5; p <= 30; p++) tick;
    check_eq("pre_rst_de", 32'(de), 32'd1);
    rst = 1'b1;
    #2;
    check_idle("async_rst");
    tick;
    rst = 1'b0;
    tick;
    check_eq("post_rst_fs", 32'(frame_start), 32'd1);
    check_eq("post_rst_rgb", 32'(rgb), 32'hFFFFFF);

`ifdef VPTG_CROSSHAIR_EN
    mode = 2'd0; solid_rgb = 24'h000000; cursor_x = 12'd5; cursor_y = 11'd3;
    for (int p = 1; p < 288; p++) tick;
    for (int p = 0; p < 288; p++) begin
      tick;
      if (p == 5)        check_eq("ch_5_0", 32'(rgb), 32'h00FF00);
      if (p == 72)       check_eq("ch_0_3", 32'(rgb), 32'h00FF00);
      if (p == 82)       check_eq("ch_10_3", 32'(rgb), 32'h00FF00);
      if (p == 149)      check_eq("ch_5_6", 32'(rgb), 32'h00FF00);
      if (p == 150)      check_eq("ch_6_6", 32'(rgb), 32'h000000);
      if (p == 28)       check_eq("ch_4_1", 32'(rgb), 32'h000000);
      if (p == 221)      check_eq("ch_5_9", 32'(rgb), 32'h000000);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
